// File: rtl/dual_port_ram_clearable.sv
// ============================================================================
// Module  : dual_port_ram_clearable
// Brief   : 1R/1W byte-enable RAM with selectable read latency and a clear sweep
// Revision: 1.0
// ============================================================================
`default_nettype none

module dual_port_ram_clearable #(
  parameter int                  ITEM_COUNT     = 800,
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  BYTE_WIDTH     = 8,
  parameter int                  READ_LATENCY   = 1,
  parameter bit                  WRITE_FIRST    = 1'b0,
  parameter bit                  CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
  parameter string               RAM_STYLE      = "auto",
  localparam int                 AddressWidth   = $clog2(ITEM_COUNT),
  localparam int                 ByteCount      = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                    clock_i,
  input  logic                    reset_ni,
  input  logic                    clear_i,
  output logic                    busy_o,
  input  logic                    read_enable_i,
  input  logic [AddressWidth-1:0] read_address_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    read_valid_o,
  input  logic                    write_enable_i,
  input  logic [ByteCount-1:0]    write_byte_enable_i,
  input  logic [AddressWidth-1:0] write_address_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i
);

  localparam logic [AddressWidth-1:0] c_last_address = AddressWidth'(ITEM_COUNT - 1);
  localparam logic [AddressWidth:0]   c_item_count   = (AddressWidth + 1)'(ITEM_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

  state_t                  r_state;
  logic [AddressWidth-1:0] r_clear_count;

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] r_mem [ITEM_COUNT];

  logic                  w_read_in_range;
  logic                  w_write_in_range;
  logic                  w_read_accept;
  logic                  w_write_accept;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_read_word;
  logic [DATA_WIDTH-1:0] w_bypass_word;
  logic [DATA_WIDTH-1:0] w_read_result;

  logic                  r_stage_valid;
  logic [DATA_WIDTH-1:0] r_stage_data;

  assign busy_o           = (r_state == ST_CLEARING);
  assign w_read_in_range  = ({1'b0, read_address_i} < c_item_count);
  assign w_write_in_range = ({1'b0, write_address_i} < c_item_count);
  assign w_read_accept    = read_enable_i & ~busy_o;
  assign w_write_accept   = write_enable_i & ~busy_o & (|write_byte_enable_i) & w_write_in_range;
  assign w_read_word      = w_read_in_range ? r_mem[read_address_i] : '0;

  // Write-first bypass: enabled lanes come from the incoming write, the rest from storage.
  for (genvar k = 0; k < ByteCount; k++) begin : g_lane
    assign w_bypass_word[k*BYTE_WIDTH +: BYTE_WIDTH] = write_byte_enable_i[k]
        ? write_data_i[k*BYTE_WIDTH +: BYTE_WIDTH]
        : w_read_word[k*BYTE_WIDTH +: BYTE_WIDTH];
  end

  assign w_collide     = WRITE_FIRST && w_write_accept && (write_address_i == read_address_i);
  assign w_read_result = w_collide ? w_bypass_word : w_read_word;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state       <= CLEAR_ON_RESET ? ST_CLEARING : ST_IDLE;
      r_clear_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_i) begin
            r_state       <= ST_CLEARING;
            r_clear_count <= '0;
          end
        end
        ST_CLEARING: begin
          if (r_clear_count == c_last_address) begin
            r_state       <= ST_IDLE;
            r_clear_count <= '0;
          end else begin
            r_clear_count <= r_clear_count + AddressWidth'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage is intentionally left out of reset; the sweep provides the known state.
  always_ff @(posedge clock_i) begin
    if (r_state == ST_CLEARING) begin
      r_mem[r_clear_count] <= CLEAR_VALUE;
    end else if (w_write_accept) begin
      for (int k = 0; k < ByteCount; k++) begin
        if (write_byte_enable_i[k]) begin
          r_mem[write_address_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= write_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
    end else begin
      r_stage_valid <= w_read_accept;
      if (w_read_accept) begin
        r_stage_data <= w_read_result;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_latency_2
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= r_stage_valid;
        if (r_stage_valid) begin
          r_out_data <= r_stage_data;
        end
      end
    end

    assign read_valid_o = r_out_valid;
    assign read_data_o  = r_out_data;
  end else begin : g_latency_1
    assign read_valid_o = r_stage_valid;
    assign read_data_o  = r_stage_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_clearable.sv
// ============================================================================
// Module  : tb_dual_port_ram_clearable
// Brief   : directed plus random bench; instance A read-first/latency 1, B write-first/latency 2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dual_port_ram_clearable;

  localparam int          ITEMS = 800;
  localparam logic [31:0] CLR   = 32'h0000_0000;

  logic        clock_i  = 1'b0;
  logic        reset_ni = 1'b1;
  logic        clear_i  = 1'b0;
  logic        re       = 1'b0;
  logic        we       = 1'b0;
  logic [3:0]  be       = 4'h0;
  logic [9:0]  ra       = '0;
  logic [9:0]  wa       = '0;
  logic [31:0] wd       = '0;

  logic        busy_a, busy_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_mem [ITEMS];
  int          left;
  logic        e1v, sv, e2v;
  logic [31:0] e1d, sd, e2d;

  always #5 clock_i = ~clock_i;

  dual_port_ram_clearable #(
    .READ_LATENCY(1), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)
  ) u_dut_a (
    .clock_i(clock_i), .reset_ni(reset_ni), .clear_i(clear_i), .busy_o(busy_a),
    .read_enable_i(re), .read_address_i(ra), .read_data_o(rdata_a), .read_valid_o(rvalid_a),
    .write_enable_i(we), .write_byte_enable_i(be), .write_address_i(wa), .write_data_i(wd)
  );

  dual_port_ram_clearable #(
    .READ_LATENCY(2), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)
  ) u_dut_b (
    .clock_i(clock_i), .reset_ni(reset_ni), .clear_i(clear_i), .busy_o(busy_b),
    .read_enable_i(re), .read_address_i(ra), .read_data_o(rdata_b), .read_valid_o(rvalid_b),
    .write_enable_i(we), .write_byte_enable_i(be), .write_address_i(wa), .write_data_i(wd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (en[k]) r[k*8 +: 8] = nw[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 10'($urandom_range(790, 1023));
    return 10'($urandom_range(0, 15));
  endfunction

  task automatic check_outputs();
    chk("busy_a", {31'b0, busy_a}, {31'b0, left > 0});
    chk("busy_b", {31'b0, busy_b}, {31'b0, left > 0});
    chk("valid_a", {31'b0, rvalid_a}, {31'b0, e1v});
    chk("data_a", rdata_a, e1d);
    chk("valid_b", {31'b0, rvalid_b}, {31'b0, e2v});
    chk("data_b", rdata_b, e2d);
  endtask

  task automatic idle();
    re = 1'b0; we = 1'b0; be = 4'h0; clear_i = 1'b0;
  endtask

  // One clock edge: predict from the inputs in force, advance, then compare.
  task automatic cycle();
    logic        busy, rd, wr, clr;
    logic [31:0] old, fresh;
    busy  = (left > 0);
    rd    = re && !busy;
    wr    = we && !busy && (be != 4'h0) && (wa < ITEMS);
    clr   = clear_i;
    old   = (ra < ITEMS) ? m_mem[ra] : 32'h0;
    fresh = (wr && wa == ra) ? merge(old, wd, be) : old;
    @(posedge clock_i);
    #1;
    if (sv) e2d = sd;
    e2v = sv;
    sv  = rd;
    if (rd) sd = fresh;
    e1v = rd;
    if (rd) e1d = old;
    if (busy) begin
      m_mem[ITEMS - left] = CLR;
      left--;
    end else begin
      if (wr) m_mem[wa] = merge(m_mem[wa], wd, be);
      if (clr) left = ITEMS;
    end
    check_outputs();
  endtask

  task automatic apply_reset(input int n);
    @(negedge clock_i);
    reset_ni = 1'b0;
    #1;
    left = ITEMS;
    e1v = 1'b0; e1d = '0; sv = 1'b0; sd = '0; e2v = 1'b0; e2d = '0;
    check_outputs();
    repeat (n) @(posedge clock_i);
    #1;
    reset_ni = 1'b1;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 2000) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n), 32'(ITEMS));
  endtask

  initial begin
    int n;
    for (int i = 0; i < ITEMS; i++) m_mem[i] = 32'h0;
    left = 0;
    e1v = 1'b0; e1d = '0; sv = 1'b0; sd = '0; e2v = 1'b0; e2d = '0;

    // Power-up sweep
    apply_reset(3);
    count_busy("reset_busy_len");

    re = 1'b1;
    ra = 10'd0;   cycle(); chk("clr_rd0", rdata_a, CLR);   chk("clr_rd0_v", {31'b0, rvalid_a}, 32'd1);
    ra = 10'd399; cycle(); chk("clr_rd399", rdata_a, CLR);
    ra = 10'd799; cycle(); chk("clr_rd799", rdata_a, CLR);
    idle(); cycle();

    // Byte-enable merge and zero-enable no-op
    we = 1'b1; wa = 10'd5;
    wd = 32'hAABB_CCDD; be = 4'b1111; cycle();
    wd = 32'h1122_3344; be = 4'b0101; cycle();
    wd = 32'hFFFF_FFFF; be = 4'b0000; cycle();
    idle(); re = 1'b1; ra = 10'd5; cycle();
    chk("byte_merge_a", rdata_a, 32'hAA22_CC44);
    idle(); cycle();
    chk("byte_merge_b", rdata_b, 32'hAA22_CC44);

    // Out-of-range access
    we = 1'b1; wa = 10'd900; wd = 32'h5555_5555; be = 4'hF; re = 1'b1; ra = 10'd900; cycle();
    chk("oor_rd", rdata_a, 32'h0); chk("oor_rd_v", {31'b0, rvalid_a}, 32'd1);
    idle(); cycle();

    // Same-address read and write
    we = 1'b1; wa = 10'd7; wd = 32'hDEAD_BEEF; be = 4'b0011; re = 1'b1; ra = 10'd7; cycle();
    chk("read_first", rdata_a, 32'h0000_0000);
    idle(); cycle();
    chk("write_first", rdata_b, 32'h0000_BEEF);
    chk("write_first_v", {31'b0, rvalid_b}, 32'd1);

    // Latency-2 streaming
    for (int i = 1; i <= 3; i++) begin
      we = 1'b1; be = 4'hF; wa = 10'(i); wd = 32'hC0DE_0000 + 32'(i); cycle();
    end
    idle();
    for (int j = 0; j < 5; j++) begin
      re = (j < 3); ra = 10'(j + 1);
      cycle();
      if (j == 0) chk("lat2_v0", {31'b0, rvalid_b}, 32'd0);
      if (j >= 1 && j <= 3) begin
        chk("lat2_data", rdata_b, 32'hC0DE_0000 + 32'(j));
        chk("lat2_v", {31'b0, rvalid_b}, 32'd1);
      end
      if (j == 4) begin
        chk("lat2_hold", rdata_b, 32'hC0DE_0003);
        chk("lat2_vlow", {31'b0, rvalid_b}, 32'd0);
      end
    end
    idle();

    // Clear request with a simultaneous write, then accesses during the sweep
    we = 1'b1; wa = 10'd10; wd = 32'h1234_5678; be = 4'hF; clear_i = 1'b1; cycle();
    idle();
    n = 0;
    while (busy_a === 1'b1 && n < 2000) begin
      idle();
      if (n == 50)  begin we = 1'b1; wa = 10'd10; wd = 32'hFFFF_0000; be = 4'hF; re = 1'b1; ra = 10'd10; end
      if (n == 100) clear_i = 1'b1;
      if (n == 799) begin re = 1'b1; ra = 10'd10; we = 1'b1; wa = 10'd10; wd = 32'h0BAD_0BAD; be = 4'hF; end
      cycle();
      n++;
    end
    chk("clear_busy_len", 32'(n), 32'(ITEMS));
    idle(); re = 1'b1; ra = 10'd10; cycle();
    chk("clr_addr10", rdata_a, CLR);
    idle(); cycle();

    // Reset in the middle of a sweep
    clear_i = 1'b1; cycle(); idle();
    repeat (300) cycle();
    apply_reset(3);
    count_busy("rst_restart_len");

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      re      = 1'($urandom_range(0, 1));
      we      = 1'($urandom_range(0, 1));
      be      = 4'($urandom_range(0, 15));
      ra      = pick_addr();
      wa      = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
      wd      = $urandom();
      clear_i = ($urandom_range(0, 399) == 0);
      cycle();
    end
    idle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
